jtkcpu_shseq: RTL
=================

Name: jtkcpu_shseq

Overview:
- Multi-bit shift sequencer for the 16-bit shift/rotate-by-count instructions: LSRD, ASRD, ASLD, RORD and ROLD, each in _IMM and _IDX forms.
- Repeatedly drives the shared ALU with the one-bit form of the opcode, feeding the result and CC back for each iteration, until the count is exhausted.
- Sits between the instruction sequencer (which supplies D, CC and the count byte) and the ALU operand/op muxes.

Parameters:
- CNTW, 8, width of the iteration counter. The count is taken from the immediate or memory byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when cen=1
- start  in  1  request; sampled only in IDLE with cen=1
- op  in  8  opcode (jtkcpu.inc constants)
- cnt  in  CNTW  number of one-bit iterations
- din  in  16  initial D value
- cc_in  in  8  initial CC
- alu_op  out  8  opcode presented to the ALU
- alu_opnd0  out  16  working accumulator presented to the ALU
- alu_cc_in  out  8  working CC presented to the ALU
- alu_rslt  in  16  ALU combinational result
- alu_cc  in  8  ALU combinational CC
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cen-cycle completion strobe
- err  out  1  high together with done if op is not a supported shift
- dout  out  16  final D; valid while done=1, held afterwards
- cc_out  out  8  final CC; valid while done=1, held afterwards

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, dout, cc_out, alu_opnd0, alu_cc_in and the counter all 0; alu_op=0.
- States: IDLE, RUN, DONE.
- IDLE, when cen and start:
  - latch op into alu_op, din into acc, cc_in into ccr, and cnt into left.
  - err_l = op not in {LSRD_*, ASRD_*, ASLD_*, RORD_*, ROLD_*}. If err_l, force left=0.
  - go to RUN; busy=1.
- RUN, each cen:
  - if left!=0: acc<=alu_rslt, ccr<=alu_cc, left<=left-1, stay in RUN.
  - if left==0: dout<=acc, cc_out<=ccr, done<=1, err<=err_l, go to DONE.
- DONE, next cen: done=0, err=0, busy=0, go to IDLE.
- alu_opnd0=acc and alu_cc_in=ccr, both registered. Every iteration therefore uses the previous iteration's C (rotations run through carry).
- Timing: start accepted in cen-cycle T. done is high in cen-cycle T+1+cnt. A new start is accepted at T+2+cnt at the earliest.
- cnt=0: done at T+1; dout=din; cc_out=cc_in unchanged (no flag update).
- No early termination and no count saturation: exactly cnt iterations.
  - LSR/ASL converge after 16 steps.
  - ROR/ROL are a 17-bit rotation and repeat with period 17.
- start while busy is ignored; no queuing.
- cen=0 freezes all registers. A done strobe stays high until the next cen cycle.
- op, cnt, din and cc_in are don't-care outside the accepting cycle.
- Reset mid-operation aborts immediately with no done strobe.

Decomposition:
- Shared package jtkcpu.inc holds:
  - opcode constants (LSRD_IMM … ROLD_IDX);
  - CC bit indices (CC_C, CC_N, CC_Z, CC_V);
  - the new state encodings SHSEQ_IDLE/RUN/DONE (2 bits).
- No sub-module: counter and FSM are small. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- ASLD_IMM, din=0x0001, cc_in=0x00, cnt=3 -> done at T+4, dout=0x0008, C=0, N=0, Z=0, err=0.
- LSRD_IDX, din=0x8001, cnt=1 -> dout=0x4000, C=1, done at T+2. Then ASRD_IMM, din=0x8000, cnt=20 -> dout=0xFFFF, N=1, C=1.
- RORD_IMM, din=0x0001, C=0, cnt=17 -> dout=0x0001, C=0 (full 17-bit rotation). With cnt=1 -> dout=0x0000, C=1, Z=1.
- cnt=0 with any valid op, cc_in=0xA5 -> done at T+1, dout=din, cc_out=0xA5. op=ADDA_IMM, cnt=9 -> err=1 with done at T+1, dout=din.
- cen alternating 1/0 during ASLD cnt=5 -> same result as cen=1, done asserted on the 7th cen-high cycle. A second start during busy is ignored and busy stays 1.
- rst_n pulled low at iteration 3 of ROLD cnt=10 -> busy, done and dout are 0 immediately (asynchronously). After release, a fresh start completes normally.

Source files
------------

// File: rtl/jtkcpu_shseq_pkg.sv
// Shared opcode constants, CC bit positions and shift-sequencer state encodings.
package jtkcpu_shseq_pkg;

    localparam logic [7:0] LSRD_IMM = 8'hA0;
    localparam logic [7:0] LSRD_IDX = 8'hA1;
    localparam logic [7:0] ASRD_IMM = 8'hA2;
    localparam logic [7:0] ASRD_IDX = 8'hA3;
    localparam logic [7:0] ASLD_IMM = 8'hA4;
    localparam logic [7:0] ASLD_IDX = 8'hA5;
    localparam logic [7:0] RORD_IMM = 8'hA6;
    localparam logic [7:0] RORD_IDX = 8'hA7;
    localparam logic [7:0] ROLD_IMM = 8'hA8;
    localparam logic [7:0] ROLD_IDX = 8'hA9;
    localparam logic [7:0] ADDA_IMM = 8'h10;

    localparam int CC_C = 0;
    localparam int CC_V = 1;
    localparam int CC_Z = 2;
    localparam int CC_N = 3;

    typedef enum logic [1:0] {
        SHSEQ_IDLE = 2'd0,
        SHSEQ_RUN  = 2'd1,
        SHSEQ_DONE = 2'd2
    } shseq_state_t;

    function automatic logic is_shift(input logic [7:0] op);
        case (op)
            LSRD_IMM, LSRD_IDX, ASRD_IMM, ASRD_IDX, ASLD_IMM,
            ASLD_IDX, RORD_IMM, RORD_IDX, ROLD_IMM, ROLD_IDX: is_shift = 1'b1;
            default:                                         is_shift = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtkcpu_shseq_if.sv
// Request/result and ALU-loop signals of the shift sequencer.
interface jtkcpu_shseq_if #(parameter int CNTW = 8);
    logic            start;
    logic [7:0]      op;
    logic [CNTW-1:0] cnt;
    logic [15:0]     din;
    logic [7:0]      cc_in;
    logic [7:0]      alu_op;
    logic [15:0]     alu_opnd0;
    logic [7:0]      alu_cc_in;
    logic [15:0]     alu_rslt;
    logic [7:0]      alu_cc;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     dout;
    logic [7:0]      cc_out;

    modport master (
        output start, op, cnt, din, cc_in, alu_rslt, alu_cc,
        input  alu_op, alu_opnd0, alu_cc_in, busy, done, err, dout, cc_out
    );

    modport slave (
        input  start, op, cnt, din, cc_in, alu_rslt, alu_cc,
        output alu_op, alu_opnd0, alu_cc_in, busy, done, err, dout, cc_out
    );
endinterface

// File: rtl/jtkcpu_shseq.sv
// Iterates the shared ALU's one-bit shift/rotate cnt times on D, feeding result and CC back.
// Latency: done rises cnt+1 cen edges after the accepting edge, for one cen cycle.
// No backpressure: start is only sampled in IDLE; requests while busy are dropped.
module jtkcpu_shseq
    import jtkcpu_shseq_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    jtkcpu_shseq_if.slave    bus
);

    shseq_state_t    state, state_nx;
    logic [7:0]      op_r;
    logic [15:0]     acc;
    logic [7:0]      ccr;
    logic [CNTW-1:0] left;
    logic            err_l;
    logic            done_r;
    logic            err_r;
    logic [15:0]     dout_r;
    logic [7:0]      cc_out_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SHSEQ_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SHSEQ_IDLE: if (cen && bus.start)     state_nx = SHSEQ_RUN;
            SHSEQ_RUN:  if (cen && left == '0)    state_nx = SHSEQ_DONE;
            SHSEQ_DONE: if (cen)                  state_nx = SHSEQ_IDLE;
            default:                              state_nx = SHSEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            acc      <= '0;
            ccr      <= '0;
            left     <= '0;
            err_l    <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            dout_r   <= '0;
            cc_out_r <= '0;
        end else if (cen) begin
            case (state)
                SHSEQ_IDLE: if (bus.start) begin
                    op_r  <= bus.op;
                    acc   <= bus.din;
                    ccr   <= bus.cc_in;
                    err_l <= !is_shift(bus.op);
                    // Unsupported ops skip straight to completion with D untouched
                    left  <= is_shift(bus.op) ? bus.cnt : '0;
                end
                SHSEQ_RUN: begin
                    if (left != '0) begin
                        acc  <= bus.alu_rslt;
                        ccr  <= bus.alu_cc;
                        left <= left - 1'b1;
                    end else begin
                        dout_r   <= acc;
                        cc_out_r <= ccr;
                        done_r   <= 1'b1;
                        err_r    <= err_l;
                    end
                end
                SHSEQ_DONE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_op    = op_r;
    assign bus.alu_opnd0 = acc;
    assign bus.alu_cc_in = ccr;
    assign bus.busy      = (state != SHSEQ_IDLE);
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.dout      = dout_r;
    assign bus.cc_out    = cc_out_r;

endmodule
